// File: rtl/apu_regops_pkg.sv
// rtl/apu_regops_pkg.sv - shared constants, index-width helper and write-entry layout for the APU register-op block
package apu_regops_pkg;

  localparam logic [15:0] APU_REG_BASE   = 16'h4000;
  localparam int          APU_NUM_REGS   = 32;
  localparam int          APU_DBG_FIRST  = 24;
  localparam int          APU_FIFO_DEPTH = 4;

  // Bits needed to index num_regs registers; never less than one bit.
  function automatic int apu_idx_width(input int num_regs);
    int w;
    w = 1;
    while ((1 << w) < num_regs) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Queued write at the default geometry: register index above data byte.
  typedef struct packed {
    logic [4:0] idx;
    logic [7:0] data;
  } apu_wr_entry_t;

endpackage

// File: rtl/apu_regops_fifo.sv
// rtl/apu_regops_fifo.sv - small synchronous write-queue FIFO with level tracking
module apu_regops_fifo
  import apu_regops_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = APU_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_level == LP_DEPTH);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];

  // A pop on the same edge frees a slot, so a push into a full queue still lands.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents are don't-care while the level says empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; reset discards everything queued.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (PTR_W+1)'(1);
        2'b01:   r_level <= r_level - (PTR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/apu_regops_gen.sv
// rtl/apu_regops_gen.sv - APU register window decoder with read select, paced write replay and overflow flag
module apu_regops_gen
  import apu_regops_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(APU_REG_BASE),
  parameter int                NUM_REGS   = APU_NUM_REGS,
  parameter int                DBG_FIRST  = APU_DBG_FIRST,
  parameter int                FIFO_DEPTH = APU_FIFO_DEPTH
) (
  input  logic                          CLK,
  input  logic                          n_RES,
  input  logic                          acc_valid,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          RnW,
  input  logic [DATA_W-1:0]             din,
  input  logic                          DBG,
  input  logic                          wr_ready,
  input  logic                          ovf_clr,
  output logic                          hit,
  output logic [NUM_REGS-1:0]           rd_sel,
  output logic [NUM_REGS-1:0]           wr_stb,
  output logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int IDX_W = apu_idx_width(NUM_REGS);
  localparam int ENT_W = IDX_W + DATA_W;
  localparam logic [ADDR_W-1:0]   LP_NUM   = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0]   LP_DBG   = ADDR_W'(DBG_FIRST);
  localparam logic [NUM_REGS-1:0] LP_ONE   = NUM_REGS'(1);

  logic [ADDR_W-1:0] w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic              w_in_win;
  logic              w_valid;
  logic              w_push;
  logic              w_rd;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic [ENT_W-1:0]  w_head;
  logic [IDX_W-1:0]  w_head_idx;
  logic [DATA_W-1:0] w_head_data;

  logic                r_hit;
  logic [NUM_REGS-1:0] r_rd_sel;
  logic [NUM_REGS-1:0] r_wr_stb;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_overflow;

  // Offset is taken at full address width; the lower-bound test keeps
  // addresses below the window from wrapping into it.
  assign w_idx_full  = addr - BASE;
  assign w_in_win    = (addr >= BASE) && (w_idx_full < LP_NUM);
  assign w_valid     = w_in_win && ((w_idx_full < LP_DBG) || DBG);
  assign w_idx       = w_idx_full[IDX_W-1:0];

  assign w_rd        = acc_valid && RnW && w_valid;
  assign w_push      = acc_valid && !RnW && w_valid;
  assign w_pop       = wr_ready && !w_empty;
  assign w_drop      = w_push && w_full && !w_pop;

  assign w_head_idx  = w_head[ENT_W-1:DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];

  apu_regops_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (CLK),
    .i_resetn (n_RES),
    .i_push   (w_push),
    .i_data   ({w_idx, din}),
    .i_pop    (w_pop),
    .o_data   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (fifo_level)
  );

  // Register the decode result: one-cycle hit and one-hot read select.
  always_ff @(posedge CLK) begin
    if (!n_RES) begin
      r_hit    <= 1'b0;
      r_rd_sel <= '0;
    end else begin
      r_hit    <= acc_valid && w_valid;
      r_rd_sel <= w_rd ? (LP_ONE << w_idx) : '0;
    end
  end

  // Replay the queue head as a single-cycle strobe whenever the consumer is ready.
  always_ff @(posedge CLK) begin
    if (!n_RES) begin
      r_wr_stb  <= '0;
      r_wr_data <= '0;
    end else if (w_pop) begin
      r_wr_stb  <= LP_ONE << w_head_idx;
      r_wr_data <= w_head_data;
    end else begin
      r_wr_stb  <= '0;
      r_wr_data <= '0;
    end
  end

  // Sticky drop flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge CLK) begin
    if (!n_RES) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign hit      = r_hit;
  assign rd_sel   = r_rd_sel;
  assign wr_stb   = r_wr_stb;
  assign wr_data  = r_wr_data;
  assign overflow = r_overflow;

endmodule
